ping_sweep_scheduler: RTL and testbench

//   Sequences the sonar front end one ping at a time: drives beam angle, burst-start pulse,

---
 rtl/ping_sweep_scheduler_if.sv | 33 +++
 rtl/ping_sweep_scheduler.sv | 169 ++++++++++++++++
 tb/tb_ping_sweep_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ping_sweep_scheduler_if.sv
// Front-end bundle between the ping sweep scheduler and its environment:
// enable/echo inputs, beam control windows and per-angle result record.
interface ping_sweep_scheduler_if #(
  parameter int ANGLE_WIDTH = 8,
  parameter int RANGE_WIDTH = 16
);
  logic                          enable_in;
  logic                          echo_valid_in;
  logic [RANGE_WIDTH-1:0]        range_in;
  logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
  logic                          burst_start_out;
  logic                          active_pulse_out;
  logic                          listen_out;
  logic                          result_valid_out;
  logic signed [ANGLE_WIDTH-1:0] result_angle_out;
  logic [RANGE_WIDTH-1:0]        result_range_out;
  logic                          result_hit_out;
  logic                          sweep_done_out;

  modport master (
    input  enable_in, echo_valid_in, range_in,
    output beam_angle_out, burst_start_out, active_pulse_out, listen_out,
           result_valid_out, result_angle_out, result_range_out,
           result_hit_out, sweep_done_out
  );

  modport slave (
    output enable_in, echo_valid_in, range_in,
    input  beam_angle_out, burst_start_out, active_pulse_out, listen_out,
           result_valid_out, result_angle_out, result_range_out,
           result_hit_out, sweep_done_out
  );
endinterface

// File: rtl/ping_sweep_scheduler.sv
// One-ping-at-a-time sonar sequencer: burst, listen, report, then step the beam angle.
// Define PING_PONG_SWEEP_EN for a back-and-forth sweep instead of wrap-around.
module ping_sweep_scheduler #(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int ANGLE_WIDTH   = 8,
  parameter int MIN_ANGLE     = -30,
  parameter int MAX_ANGLE     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int RANGE_WIDTH   = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  ping_sweep_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int AW1   = ANGLE_WIDTH + 1;

  localparam logic [CNT_W-1:0]      BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0]      LISTEN_LAST = CNT_W'(PERIOD_CYCLES - 2);
  localparam logic signed [AW1-1:0] MIN_W       = AW1'(MIN_ANGLE);
  localparam logic signed [AW1-1:0] MAX_W       = AW1'(MAX_ANGLE);
  localparam logic signed [AW1-1:0] STEP_W      = AW1'(ANGLE_STEP);
  localparam logic signed [ANGLE_WIDTH-1:0] MIN_A = ANGLE_WIDTH'(MIN_ANGLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_LISTEN,
    S_REPORT
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CNT_W-1:0]              r_cnt;
  logic signed [ANGLE_WIDTH-1:0] r_angle;
  logic                          r_hit;
  logic [RANGE_WIDTH-1:0]        r_range;
  logic signed [ANGLE_WIDTH-1:0] r_res_angle;
  logic [RANGE_WIDTH-1:0]        r_res_range;
  logic                          r_res_hit;

  logic signed [AW1-1:0]         w_angle_ext;
  logic signed [AW1-1:0]         w_up;
  logic signed [ANGLE_WIDTH-1:0] w_angle_nxt;
  logic                          w_sweep_end;
  logic                          w_echo_take;

`ifdef PING_PONG_SWEEP_EN
  logic                          r_dir;
  logic                          w_dir_nxt;
  logic signed [AW1-1:0]         w_dn;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.enable_in) w_state_nxt = S_BURST;
      S_BURST:  if (r_cnt == BURST_LAST) w_state_nxt = S_LISTEN;
      S_LISTEN: if (r_cnt == LISTEN_LAST) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = bus.enable_in ? S_BURST : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Angle maths is one bit wider so the bound compare cannot overflow.
  always_comb begin
    w_angle_ext = {r_angle[ANGLE_WIDTH-1], r_angle};
    w_up        = w_angle_ext + STEP_W;
`ifdef PING_PONG_SWEEP_EN
    w_dn        = w_angle_ext - STEP_W;
    w_dir_nxt   = r_dir;
    w_sweep_end = 1'b0;
    if (!r_dir) begin
      if (w_up > MAX_W) begin
        w_sweep_end = 1'b1;
        w_dir_nxt   = 1'b1;
        w_angle_nxt = w_dn[ANGLE_WIDTH-1:0];
      end else begin
        w_angle_nxt = w_up[ANGLE_WIDTH-1:0];
      end
    end else begin
      if (w_dn < MIN_W) begin
        w_sweep_end = 1'b1;
        w_dir_nxt   = 1'b0;
        w_angle_nxt = w_up[ANGLE_WIDTH-1:0];
      end else begin
        w_angle_nxt = w_dn[ANGLE_WIDTH-1:0];
      end
    end
`else
    w_sweep_end = (w_up > MAX_W);
    w_angle_nxt = w_sweep_end ? MIN_W[ANGLE_WIDTH-1:0] : w_up[ANGLE_WIDTH-1:0];
`endif
  end

  assign w_echo_take = bus.echo_valid_in && !r_hit;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_angle     <= MIN_A;
      r_hit       <= 1'b0;
      r_range     <= '0;
      r_res_angle <= '0;
      r_res_range <= '0;
      r_res_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_hit   <= 1'b0;
          r_range <= '0;
          r_angle <= MIN_A;
        end
        S_BURST: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_LISTEN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_echo_take) begin
            r_hit   <= 1'b1;
            r_range <= bus.range_in;
          end
          // Result is formed here so an echo on the final listen cycle still counts.
          if (r_cnt == LISTEN_LAST) begin
            r_res_angle <= r_angle;
            r_res_hit   <= r_hit || bus.echo_valid_in;
            r_res_range <= r_hit ? r_range : (bus.echo_valid_in ? bus.range_in : '0);
          end
        end
        S_REPORT: begin
          r_cnt   <= '0;
          r_hit   <= 1'b0;
          r_range <= '0;
          r_angle <= bus.enable_in ? w_angle_nxt : MIN_A;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PING_PONG_SWEEP_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_dir <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_dir <= 1'b0;
    end else if (r_state == S_REPORT) begin
      r_dir <= bus.enable_in ? w_dir_nxt : 1'b0;
    end
  end
`endif

  assign bus.beam_angle_out   = r_angle;
  assign bus.burst_start_out  = (r_state == S_BURST) && (r_cnt == '0);
  assign bus.active_pulse_out = (r_state == S_BURST);
  assign bus.listen_out       = (r_state == S_LISTEN);
  assign bus.result_valid_out = (r_state == S_REPORT);
  assign bus.result_angle_out = r_res_angle;
  assign bus.result_range_out = r_res_range;
  assign bus.result_hit_out   = r_res_hit;
  assign bus.sweep_done_out   = (r_state == S_REPORT) && w_sweep_end;

endmodule

// File: tb/tb_ping_sweep_scheduler.sv
// Scoreboard bench for ping_sweep_scheduler with a short ping (100 cycles, 10 burst).
module tb_ping_sweep_scheduler;
  localparam int PER = 100;
  localparam int BUR = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ping_sweep_scheduler_if #(.ANGLE_WIDTH(8), .RANGE_WIDTH(16)) bus_if ();

  ping_sweep_scheduler #(
    .PERIOD_CYCLES(PER),
    .BURST_CYCLES (BUR),
    .ANGLE_WIDTH  (8),
    .MIN_ANGLE    (-30),
    .MAX_ANGLE    (30),
    .ANGLE_STEP   (10),
    .RANGE_WIDTH  (16)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus_if)
  );

  typedef struct {
    int angle;
    int range;
    int hit;
    int done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int   m_angle = -30;
  int   m_dir   = 0;

  int   mon_pos = 0;
  int   mon_act = 0;
  int   mon_lis = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Bench sweep model: returns the expected done flag and advances the angle.
  function automatic int model_step();
    int done;
`ifdef PING_PONG_SWEEP_EN
    if (m_dir == 0) begin
      done = (m_angle + 10 > 30) ? 1 : 0;
      if (done != 0) begin m_dir = 1; m_angle = m_angle - 10; end
      else m_angle = m_angle + 10;
    end else begin
      done = (m_angle - 10 < -30) ? 1 : 0;
      if (done != 0) begin m_dir = 0; m_angle = m_angle + 10; end
      else m_angle = m_angle - 10;
    end
`else
    done = (m_angle + 10 > 30) ? 1 : 0;
    m_angle = (done != 0) ? -30 : m_angle + 10;
`endif
    return done;
  endfunction

  always @(negedge clk) begin
    if (bus_if.burst_start_out) begin
      mon_pos = 0; mon_act = 0; mon_lis = 0;
    end else begin
      mon_pos++;
    end
    if (bus_if.active_pulse_out) mon_act++;
    if (bus_if.listen_out) mon_lis++;
    if (bus_if.sweep_done_out && !bus_if.result_valid_out) begin
      checks++; failures++;
      $display("FAIL sweep_done_alone actual=1 expected=0");
    end
    if (bus_if.result_valid_out) begin
      chk("result_pos", mon_pos, PER - 1);
      chk("active_len", mon_act, BUR);
      chk("listen_len", mon_lis, PER - BUR - 1);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=1 expected=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_angle", bus_if.result_angle_out, e.angle);
        chk("result_range", {16'd0, bus_if.result_range_out}, e.range);
        chk("result_hit",   {31'd0, bus_if.result_hit_out}, e.hit);
        chk("sweep_done",   {31'd0, bus_if.sweep_done_out}, e.done);
      end
    end
  end

  task automatic check_quiet(input string tag, input int exp_angle);
    chk({tag, "_burst"},  {31'd0, bus_if.burst_start_out}, 0);
    chk({tag, "_active"}, {31'd0, bus_if.active_pulse_out}, 0);
    chk({tag, "_listen"}, {31'd0, bus_if.listen_out}, 0);
    chk({tag, "_valid"},  {31'd0, bus_if.result_valid_out}, 0);
    chk({tag, "_done"},   {31'd0, bus_if.sweep_done_out}, 0);
    chk({tag, "_angle"},  bus_if.beam_angle_out, exp_angle);
  endtask

  // One ping: echoes at cnt ca/cb (-1 = none); enable drops at drop_at; reset at rst_at.
  task automatic ping(input int ca, input logic [15:0] ra, input int cb, input logic [15:0] rb,
                      input int er, input int eh, input int drop_at, input int rst_at);
    int   waited = 0;
    exp_t e;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus_if.burst_start_out && waited < 200);
    if (!bus_if.burst_start_out) begin
      checks++; failures++;
      $display("FAIL burst_timeout actual=%0d expected=1", waited);
      return;
    end
    chk("burst_latency", waited, 1);
    e.angle = m_angle; e.range = er; e.hit = eh;
    e.done  = model_step();
    sb.push_back(e);
    if (drop_at >= 0) begin m_angle = -30; m_dir = 0; end
    for (int c = 0; c < PER; c++) begin
      bus_if.echo_valid_in = 1'b0;
      if (c == ca) begin bus_if.echo_valid_in = 1'b1; bus_if.range_in = ra; end
      if (c == cb) begin bus_if.echo_valid_in = 1'b1; bus_if.range_in = rb; end
      if (c == drop_at) bus_if.enable_in = 1'b0;
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        check_quiet("midrst", -30);
        chk("midrst_res_angle", bus_if.result_angle_out, 0);
        chk("midrst_res_range", {16'd0, bus_if.result_range_out}, 0);
        chk("midrst_res_hit",   {31'd0, bus_if.result_hit_out}, 0);
        void'(sb.pop_back());
        bus_if.echo_valid_in = 1'b0;
        m_angle = -30; m_dir = 0;
        return;
      end
      if (c < PER - 1) @(negedge clk);
    end
    bus_if.echo_valid_in = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.enable_in     = 1'b0;
    bus_if.echo_valid_in = 1'b0;
    bus_if.range_in      = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset", -30);
    chk("reset_res_angle", bus_if.result_angle_out, 0);
    chk("reset_res_range", {16'd0, bus_if.result_range_out}, 0);
    chk("reset_res_hit",   {31'd0, bus_if.result_hit_out}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("idle0", -30);

    bus_if.enable_in = 1'b1;
    ping(40, 16'h0123, 60, 16'h0456, 'h0123, 1, -1, -1); // -30
    ping( 5, 16'h0777, -1, 16'h0000, 0,      0, -1, -1); // -20 burst-only echo
    ping(98, 16'h0abc, -1, 16'h0000, 'h0abc, 1, -1, -1); // -10 last listen cycle
    ping( 9, 16'h0111, 10, 16'h0222, 'h0222, 1, -1, -1); //   0 burst edge
    ping(-1, 16'h0000, -1, 16'h0000, 0,      0, -1, -1); //  10
    ping(97, 16'h0444, 99, 16'h0333, 'h0444, 1, -1, -1); //  20 echo in report ignored
    ping(20, 16'h0555, -1, 16'h0000, 'h0555, 1, -1, -1); //  30 end of sweep
    ping(70, 16'h0888, -1, 16'h0000, 'h0888, 1, 50, -1); // enable drops mid-ping

    repeat (3) begin
      @(negedge clk);
      check_quiet("idle1", -30);
    end
    chk("hold_res_range", {16'd0, bus_if.result_range_out}, 'h0888);
    chk("hold_res_hit",   {31'd0, bus_if.result_hit_out}, 1);

    bus_if.enable_in = 1'b1;
    ping(30, 16'h0999, -1, 16'h0000, 'h0999, 1, -1, -1); // -30 again
    ping(20, 16'h0aaa, -1, 16'h0000, 'h0aaa, 1, -1, 40); // reset mid-listen
    bus_if.enable_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("post_rst", -30);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
